// File: rtl/gc_ctrl_array.sv
// gc_ctrl_array: N_CH independent Start/Sensor/Actuator controllers.
// Each channel synchronises and debounces its active-low start and
// active-high sensor. It sets the actuator on start-low with sensor-low and
// clears it when the sensor rises. A channel left ON too long is tripped
// into a sticky fault.
module gc_ctrl_array #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 8,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      start_n,
    input  logic [N_CH-1:0]      sensor,
    input  logic [TIMEOUT_W-1:0] timeout_lim,
    input  logic [N_CH-1:0]      fault_clr,
    output logic [N_CH-1:0]      actuator,
    output logic [N_CH-1:0]      fault,
    output logic                 busy
);

    // Start bits occupy [N_CH-1:0] and sensor bits occupy [2*N_CH-1:N_CH] of
    // the input path, so a single filter can serve both inputs.
    localparam int NB    = 2 * N_CH;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {ST_OFF, ST_ON, ST_FAULT} state_t;

    logic [NB-1:0]        sync_q [SYNC_STAGES];
    logic [NB-1:0]        raw_s;
    logic [NB-1:0]        filt;
    logic [CNT_W-1:0]     cnt [NB];
    state_t               state [N_CH];
    logic [TIMEOUT_W-1:0] timer [N_CH];
    logic [N_CH-1:0]      st_f;
    logic [N_CH-1:0]      se_f;
    logic [N_CH-1:0]      set_cond;
    logic [N_CH-1:0]      tmo_hit;
    logic [N_CH-1:0]      next_act;

    // Synchroniser chain; idles high so that reset looks like "no start, sensor high".
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= {sensor, start_n};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign raw_s = sync_q[SYNC_STAGES-1];

    // Debounce: the filtered bit only follows raw_s after DEBOUNCE consecutive mismatching cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= '1;
            for (int b = 0; b < NB; b++) cnt[b] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (raw_s[b] == filt[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_LAST) begin
                    filt[b] <= raw_s[b];
                    cnt[b]  <= '0;
                end else begin
                    cnt[b] <= cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    assign st_f = filt[N_CH-1:0];
    assign se_f = filt[NB-1:N_CH];

    // Per-channel transition conditions; next_act lets busy line up with actuator.
    always_comb begin
        set_cond = '0;
        tmo_hit  = '0;
        next_act = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            set_cond[ch] = !st_f[ch] && !se_f[ch];
            tmo_hit[ch]  = (timeout_lim != '0) &&
                           (timer[ch] == timeout_lim - TIMEOUT_W'(1));
            next_act[ch] = ((state[ch] == ST_OFF) && set_cond[ch]) ||
                           ((state[ch] == ST_ON) && !se_f[ch] && !tmo_hit[ch]);
        end
    end

    // Channel FSMs with registered outputs. Sensor-high takes priority over the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                state[ch] <= ST_OFF;
                timer[ch] <= '0;
            end
            actuator <= '0;
            fault    <= '0;
            busy     <= 1'b0;
        end else begin
            busy <= |next_act;
            for (int ch = 0; ch < N_CH; ch++) begin
                case (state[ch])
                    ST_OFF: begin
                        if (set_cond[ch]) begin
                            state[ch]    <= ST_ON;
                            actuator[ch] <= 1'b1;
                            timer[ch]    <= '0;
                        end
                    end
                    ST_ON: begin
                        if (se_f[ch]) begin
                            state[ch]    <= ST_OFF;
                            actuator[ch] <= 1'b0;
                            timer[ch]    <= '0;
                        end else if (tmo_hit[ch]) begin
                            state[ch]    <= ST_FAULT;
                            actuator[ch] <= 1'b0;
                            fault[ch]    <= 1'b1;
                            timer[ch]    <= '0;
                        end else if (timer[ch] != '1) begin
                            timer[ch] <= timer[ch] + TIMEOUT_W'(1);
                        end
                    end
                    ST_FAULT: begin
                        actuator[ch] <= 1'b0;
                        if (fault_clr[ch]) begin
                            state[ch] <= ST_OFF;
                            fault[ch] <= 1'b0;
                        end
                    end
                    default: begin
                        state[ch]    <= ST_OFF;
                        actuator[ch] <= 1'b0;
                        fault[ch]    <= 1'b0;
                        timer[ch]    <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gc_ctrl_array.sv
// Testbench for gc_ctrl_array: directed stimulus, literal checks and a
// cycle-by-cycle comparison against a window/elapsed-time reference model.
module tb_gc_ctrl_array;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int D  = 8;
    localparam int TW = 16;
    localparam int HL = S + D - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  start_n;
    logic [N-1:0]  sensor;
    logic [N-1:0]  fault_clr;
    logic [TW-1:0] timeout_lim;
    logic [N-1:0]  actuator;
    logic [N-1:0]  fault;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    // hist[b][0] is the newest sample of input bit b.
    // flt holds the filtered value.
    // m_elapsed counts edges since the channel turned on.
    bit         model_ok = 1'b0;
    bit         hist [2*N][HL];
    bit         flt [2*N];
    bit         m_on [N];
    bit         m_fault [N];
    int         m_elapsed [N];
    logic [N-1:0] exp_act;
    logic [N-1:0] exp_fault;
    logic         exp_busy;

    always #5 clk = ~clk;

    gc_ctrl_array #(
        .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE(D), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_n(start_n),
        .sensor(sensor),
        .timeout_lim(timeout_lim),
        .fault_clr(fault_clr),
        .actuator(actuator),
        .fault(fault),
        .busy(busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] st, input logic [N-1:0] se);
        @(negedge clk);
        start_n = st;
        sensor  = se;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic modelStep();
        logic [2*N-1:0] inbits;
        bit differ;
        inbits = {sensor, start_n};
        if (rst) begin
            for (int b = 0; b < 2*N; b++) begin
                flt[b] = 1'b1;
                for (int k = 0; k < HL; k++) hist[b][k] = 1'b1;
            end
            for (int ch = 0; ch < N; ch++) begin
                m_on[ch] = 1'b0; m_fault[ch] = 1'b0; m_elapsed[ch] = 0;
            end
            model_ok = 1'b1;
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                if (m_fault[ch]) begin
                    if (fault_clr[ch]) m_fault[ch] = 1'b0;
                end else if (m_on[ch]) begin
                    m_elapsed[ch]++;
                    if (flt[N+ch]) begin
                        m_on[ch] = 1'b0;
                    end else if (timeout_lim != 0 && m_elapsed[ch] == int'(timeout_lim)) begin
                        m_on[ch] = 1'b0;
                        m_fault[ch] = 1'b1;
                    end
                end else if (!flt[ch] && !flt[N+ch]) begin
                    m_on[ch] = 1'b1;
                    m_elapsed[ch] = 0;
                end
            end
            for (int b = 0; b < 2*N; b++) begin
                differ = 1'b1;
                for (int k = S-1; k < HL; k++)
                    if (hist[b][k] == flt[b]) differ = 1'b0;
                if (differ) flt[b] = ~flt[b];
                for (int k = HL-1; k > 0; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = inbits[b];
            end
        end
        for (int ch = 0; ch < N; ch++) begin
            exp_act[ch]   = m_on[ch];
            exp_fault[ch] = m_fault[ch];
        end
        exp_busy = |exp_act;
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            checkOutput("cyc_actuator", actuator, exp_act);
            checkOutput("cyc_fault", fault, exp_fault);
            checkOutput("cyc_busy", busy, exp_busy);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start_n = '1; sensor = '1; fault_clr = '0; timeout_lim = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_actuator", actuator, 4'h0);
        checkOutput("reset_fault", fault, 4'h0);
        checkOutput("reset_busy", busy, 1'b0);

        // Single-channel replay on ch0
        applyStimulus(4'hF, 4'hE); waitEdges(12);
        checkOutput("t1_sensor_only", actuator, 4'h0);
        applyStimulus(4'hE, 4'hE); waitEdges(10);
        checkOutput("t1_set_early", actuator, 4'h0);
        waitEdges(1);
        checkOutput("t1_set", actuator, 4'h1);
        checkOutput("model_t1_set", exp_act, 4'h1);
        applyStimulus(4'hE, 4'hF); waitEdges(10);
        checkOutput("t1_clr_early", actuator, 4'h1);
        waitEdges(1);
        checkOutput("t1_clr", actuator, 4'h0);
        applyStimulus(4'hE, 4'hE); waitEdges(10);
        checkOutput("t1_reset_early", actuator, 4'h0);
        waitEdges(1);
        checkOutput("t1_reset", actuator, 4'h1);
        applyStimulus(4'hF, 4'hE); waitEdges(15);
        checkOutput("t1_latch", actuator, 4'h1);
        applyStimulus(4'hF, 4'hF); waitEdges(10);
        checkOutput("t1_off_early", actuator, 4'h1);
        waitEdges(1);
        checkOutput("t1_off", actuator, 4'h0);
        checkOutput("t1_busy_off", busy, 1'b0);

        // Glitch rejection: 7-sample pulse is filtered, 8-sample pulse is not
        applyStimulus(4'hE, 4'hE); waitEdges(11);
        checkOutput("t2_on", actuator, 4'h1);
        applyStimulus(4'hE, 4'hF);
        repeat (6) @(negedge clk);
        applyStimulus(4'hE, 4'hE); waitEdges(20);
        checkOutput("t2_glitch7", actuator, 4'h1);
        applyStimulus(4'hE, 4'hF);
        repeat (7) @(negedge clk);
        applyStimulus(4'hE, 4'hE); waitEdges(2);
        checkOutput("t2_glitch8_early", actuator, 4'h1);
        waitEdges(1);
        checkOutput("t2_glitch8", actuator, 4'h0);
        waitEdges(8);
        checkOutput("t2_recover", actuator, 4'h1);
        applyStimulus(4'hF, 4'hF); waitEdges(12);

        // Timeout and fault clear on ch2
        timeout_lim = 16'd20;
        applyStimulus(4'hB, 4'hB); waitEdges(11);
        checkOutput("t3_on", actuator, 4'h4);
        waitEdges(19);
        checkOutput("t3_before_tmo", actuator, 4'h4);
        checkOutput("t3_before_tmo_fault", fault, 4'h0);
        waitEdges(1);
        checkOutput("t3_tmo_act", actuator, 4'h0);
        checkOutput("t3_tmo_fault", fault, 4'h4);
        checkOutput("model_t3_fault", exp_fault, 4'h4);
        waitEdges(3);
        @(negedge clk); fault_clr = 4'h4;
        waitEdges(1);
        checkOutput("t3_clr_fault", fault, 4'h0);
        checkOutput("t3_clr_act", actuator, 4'h0);
        @(negedge clk); fault_clr = 4'h0;
        waitEdges(1);
        checkOutput("t3_rerise", actuator, 4'h4);
        applyStimulus(4'hF, 4'hF); waitEdges(12);
        checkOutput("t3_release", actuator, 4'h0);
        checkOutput("t3_release_fault", fault, 4'h0);

        // Sensor arrives on the timeout cycle on ch1
        applyStimulus(4'hD, 4'hD); waitEdges(11);
        checkOutput("t4_on", actuator, 4'h2);
        waitEdges(9);
        applyStimulus(4'hD, 4'hF); waitEdges(10);
        checkOutput("t4_before", actuator, 4'h2);
        waitEdges(1);
        checkOutput("t4_off", actuator, 4'h0);
        checkOutput("t4_no_fault", fault, 4'h0);
        checkOutput("model_t4_fault", exp_fault, 4'h0);
        waitEdges(5);
        checkOutput("t4_no_fault_late", fault, 4'h0);
        applyStimulus(4'hF, 4'hF); waitEdges(12);

        // Channel independence
        timeout_lim = 16'd0;
        applyStimulus(4'h0, 4'h0); waitEdges(10);
        checkOutput("t5_early", actuator, 4'h0);
        waitEdges(1);
        checkOutput("t5_all", actuator, 4'hF);
        checkOutput("t5_busy", busy, 1'b1);
        applyStimulus(4'h0, 4'h2); waitEdges(10);
        checkOutput("t5_hold", actuator, 4'hF);
        waitEdges(1);
        checkOutput("t5_ch1_off", actuator, 4'hD);
        checkOutput("t5_busy_still", busy, 1'b1);
        checkOutput("model_t5", exp_act, 4'hD);

        // Reset with ch0 ON and ch3 in FAULT
        applyStimulus(4'hF, 4'hF); waitEdges(12);
        checkOutput("t6_idle", actuator, 4'h0);
        timeout_lim = 16'd20;
        applyStimulus(4'h7, 4'h7); waitEdges(11);
        checkOutput("t6_ch3_on", actuator, 4'h8);
        waitEdges(20);
        checkOutput("t6_ch3_fault", fault, 4'h8);
        timeout_lim = 16'd0;
        applyStimulus(4'h6, 4'h6); waitEdges(11);
        checkOutput("t6_ch0_on", actuator, 4'h1);
        checkOutput("t6_fault_held", fault, 4'h8);
        @(negedge clk); rst = 1'b1;
        waitEdges(1);
        checkOutput("t6_rst_act", actuator, 4'h0);
        checkOutput("t6_rst_fault", fault, 4'h0);
        checkOutput("t6_rst_busy", busy, 1'b0);
        @(negedge clk); rst = 1'b0;
        waitEdges(10);
        checkOutput("t6_post_early", actuator, 4'h0);
        waitEdges(1);
        checkOutput("t6_post_rise", actuator, 4'h9);
        checkOutput("t6_post_busy", busy, 1'b1);
        waitEdges(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
